pulse_out_module: RTL and testbench

PULSE_OUT_MODULE -- requirements
Module: pulse_out_module

---
 rtl/key_io_pkg.sv | 15 +
 rtl/ms_tick_gen.sv | 29 ++
 rtl/pulse_out_module.sv | 121 ++++++++++++
 tb/tb_pulse_out_module.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_io_pkg.sv
// Shared constants and state encoding for the key/pulse I/O blocks.
package key_io_pkg;

    localparam logic [15:0] T1MS_DEF    = 16'd49_999;
    localparam logic [6:0]  HIGH_MS_DEF = 7'd20;
    localparam logic [6:0]  GAP_MS_DEF  = 7'd20;
    localparam int          PEND_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond timebase: counts while run is high, emits one tick per wrap at T1MS.
module ms_tick_gen #(
    parameter logic [15:0] T1MS = 16'd49_999
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic run,
    output logic tick
);

    logic [15:0] cnt_q, cnt_d;

    // Held at zero while stopped so every run starts from a clean millisecond.
    always_comb begin
        cnt_d = 16'd0;
        if (run && (cnt_q != T1MS))
            cnt_d = cnt_q + 16'd1;
    end

    assign tick = run && (cnt_q == T1MS);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pulse_out_module.sv
// Fixed-width pulse driver with a minimum gap and an optional request queue.
// Define PULSE_OUT_QUEUE_EN to queue triggers that arrive while busy.
module pulse_out_module
    import key_io_pkg::*;
#(
    parameter logic [15:0] T1MS    = T1MS_DEF,
    parameter logic [6:0]  HIGH_MS = HIGH_MS_DEF,
    parameter logic [6:0]  GAP_MS  = GAP_MS_DEF,
    parameter int          PEND_W  = PEND_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Trig_Sig,
    output logic              Pin_Out,
    output logic              Busy,
    output logic [PEND_W-1:0] Pend_Cnt,
    output logic              Drop_Sig
);

    pulse_state_t state_q, state_d;
    logic [6:0]   ms_q, ms_d;
    logic         tick;
    logic         phase_end;
    logic         gap_end;
    logic         busy_trig;
    logic         pin_q, busy_q, drop_q, drop_d;

    ms_tick_gen #(.T1MS(T1MS)) u_tick (
        .CLK  (CLK),
        .RSTn (RSTn),
        .run  (state_q != IDLE),
        .tick (tick)
    );

    assign phase_end = tick && (ms_q == ((state_q == HIGH) ? (HIGH_MS - 7'd1) : (GAP_MS - 7'd1)));
    assign gap_end   = (state_q == GAP) && phase_end;
    assign busy_trig = Trig_Sig && (state_q != IDLE);

`ifdef PULSE_OUT_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] pend_q, pend_d;

    // A trigger on the last GAP cycle restarts HIGH directly, so it cancels the dequeue.
    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        if (gap_end) begin
            if ((pend_q != '0) && !Trig_Sig)
                pend_d = pend_q - 1'b1;
        end else if (busy_trig) begin
            if (pend_q != PEND_MAX)
                pend_d = pend_q + 1'b1;
            else
                drop_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    assign Pend_Cnt = pend_q;
`else
    always_comb begin
        drop_d = busy_trig;
    end

    assign Pend_Cnt = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (Trig_Sig) state_d = HIGH;
            HIGH: if (phase_end) state_d = GAP;
            GAP: begin
                if (phase_end) begin
`ifdef PULSE_OUT_QUEUE_EN
                    state_d = ((pend_q != '0) || Trig_Sig) ? HIGH : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Millisecond count within the current phase; every phase change lands on a tick.
    always_comb begin
        ms_d = ms_q;
        if ((state_q == IDLE) || phase_end)
            ms_d = 7'd0;
        else if (tick)
            ms_d = ms_q + 7'd1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            ms_q    <= 7'd0;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            pin_q   <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
            drop_q  <= drop_d;
        end
    end

    assign Pin_Out  = pin_q;
    assign Busy     = busy_q;
    assign Drop_Sig = drop_q;

endmodule

// File: tb/tb_pulse_out_module.sv
// Self-checking bench for pulse_out_module (10 cycles/ms, 2 ms high, 3 ms gap, 2-bit queue).
// Follows the PULSE_OUT_QUEUE_EN setting of the build.
module tb_pulse_out_module;

    localparam int HIGH_CYC = 20;
    localparam int GAP_CYC  = 30;
    localparam int PEND_MAX = 3;
`ifdef PULSE_OUT_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       CLK;
    logic       RSTn;
    logic       Trig_Sig;
    logic       Pin_Out;
    logic       Busy;
    logic [1:0] Pend_Cnt;
    logic       Drop_Sig;

    pulse_out_module #(
        .T1MS    (16'd9),
        .HIGH_MS (7'd2),
        .GAP_MS  (7'd3),
        .PEND_W  (2)
    ) u_dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Trig_Sig (Trig_Sig),
        .Pin_Out  (Pin_Out),
        .Busy     (Busy),
        .Pend_Cnt (Pend_Cnt),
        .Drop_Sig (Drop_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: phase (0 idle, 1 high, 2 gap) with cycles remaining in it.
    int mPhase = 0;
    int mLeft  = 0;
    int mPend  = 0;
    bit mDrop  = 1'b0;

    int cyc;
    bit pinLog  [0:511];
    bit busyLog [0:511];
    bit dropLog [0:511];
    int pendLog [0:511];

    typedef struct {
        int cycle;
        bit pin;
        bit busy;
    } vec_t;
    vec_t tbl [9];

    task automatic checkVal(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mLeft  = 0;
        mPend  = 0;
        mDrop  = 1'b0;
    endtask

    task automatic modelEnqueue();
        if (QEN && (mPend < PEND_MAX))
            mPend++;
        else
            mDrop = 1'b1;
    endtask

    task automatic modelStep(input bit trig);
        mDrop = 1'b0;
        case (mPhase)
            0: if (trig) begin
                mPhase = 1;
                mLeft  = HIGH_CYC;
            end
            1: begin
                if (trig) modelEnqueue();
                mLeft--;
                if (mLeft == 0) begin
                    mPhase = 2;
                    mLeft  = GAP_CYC;
                end
            end
            default: begin
                mLeft--;
                if (mLeft == 0) begin
                    if (QEN && ((mPend > 0) || trig)) begin
                        if (!trig) mPend--;
                        mPhase = 1;
                        mLeft  = HIGH_CYC;
                    end else begin
                        mPhase = 0;
                        if (trig) mDrop = 1'b1;
                    end
                end else if (trig) begin
                    modelEnqueue();
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".pin"},  int'(Pin_Out),  int'(mPhase == 1));
        checkVal({tag, ".busy"}, int'(Busy),     int'(mPhase != 0));
        checkVal({tag, ".pend"}, int'(Pend_Cnt), mPend);
        checkVal({tag, ".drop"}, int'(Drop_Sig), int'(mDrop));
    endtask

    task automatic logNow();
        if (cyc < 512) begin
            pinLog[cyc]  = Pin_Out;
            busyLog[cyc] = Busy;
            dropLog[cyc] = Drop_Sig;
            pendLog[cyc] = int'(Pend_Cnt);
        end
    endtask

    task automatic startScenario();
        cyc = 0;
        logNow();
    endtask

    // Drive one cycle of Trig_Sig, then sample 1 time unit after the edge.
    task automatic applyStimulus(input bit trig, input string tag);
        Trig_Sig = trig;
        @(posedge CLK);
        modelStep(trig);
        #1;
        Trig_Sig = 1'b0;
        cyc++;
        logNow();
        checkOutput(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 500; i++) begin
            if ((mPhase == 0) && (mPend == 0)) break;
            applyStimulus(1'b0, tag);
        end
        checkVal({tag, ".drainIdle"}, mPhase, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".pin"},   int'(Pin_Out),  0);
        checkVal({tag, ".busy"},  int'(Busy),     0);
        checkVal({tag, ".pend"},  int'(Pend_Cnt), 0);
        checkVal({tag, ".drop"},  int'(Drop_Sig), 0);
        checkVal({tag, ".msCnt"}, int'(u_dut.u_tick.cnt_q), 0);
    endtask

    initial begin
        int cntBad;
        int pulses;
        int drops;
        int maxPend;
        int highCycles;

        tbl[0] = '{0,  1'b0, 1'b0};
        tbl[1] = '{1,  1'b1, 1'b1};
        tbl[2] = '{10, 1'b1, 1'b1};
        tbl[3] = '{20, 1'b1, 1'b1};
        tbl[4] = '{21, 1'b0, 1'b1};
        tbl[5] = '{35, 1'b0, 1'b1};
        tbl[6] = '{50, 1'b0, 1'b1};
        tbl[7] = '{51, 1'b0, 1'b0};
        tbl[8] = '{60, 1'b0, 1'b0};

        cyc      = 0;
        RSTn     = 1'b0;
        Trig_Sig = 1'b0;
        #1;
        checkAllZero("powerUpReset");
        modelReset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;

        // Long idle stretch: nothing moves, timebase stays parked.
        cntBad = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b0, "idle");
            if (u_dut.u_tick.cnt_q != 16'd0) cntBad++;
        end
        checkVal("idleMsCounterNonZero", cntBad, 0);

        // Single trigger against the directed table.
        startScenario();
        applyStimulus(1'b1, "single");
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, "single");
        foreach (tbl[i]) begin
            checkVal($sformatf("singleTbl.pin@%0d", tbl[i].cycle),  int'(pinLog[tbl[i].cycle]),  int'(tbl[i].pin));
            checkVal($sformatf("singleTbl.busy@%0d", tbl[i].cycle), int'(busyLog[tbl[i].cycle]), int'(tbl[i].busy));
        end

        // Two triggers at cycles 0 and 5.
        startScenario();
        for (int i = 0; i < 110; i++) applyStimulus((i == 0) || (i == 5), "double");
        checkVal("double.pend@5",  pendLog[5],  0);
        checkVal("double.pend@6",  pendLog[6],  QEN ? 1 : 0);
        checkVal("double.pend@50", pendLog[50], QEN ? 1 : 0);
        checkVal("double.pend@51", pendLog[51], 0);
        checkVal("double.drop@6",  int'(dropLog[6]),  QEN ? 0 : 1);
        checkVal("double.pin@51",  int'(pinLog[51]),  QEN ? 1 : 0);
        checkVal("double.pin@70",  int'(pinLog[70]),  QEN ? 1 : 0);
        checkVal("double.pin@71",  int'(pinLog[71]),  0);
        checkVal("double.busy@101", int'(busyLog[101]), 0);
        drain("double");

        // Start plus five triggers during the first HIGH: queue saturates.
        startScenario();
        for (int i = 0; i < 300; i++)
            applyStimulus((i == 0) || (i == 2) || (i == 4) || (i == 6) || (i == 8) || (i == 10), "burst");
        pulses = 0;
        drops = 0;
        maxPend = 0;
        for (int i = 1; i <= 300; i++) begin
            if (pinLog[i] && !pinLog[i-1]) pulses++;
            if (dropLog[i]) drops++;
            if (pendLog[i] > maxPend) maxPend = pendLog[i];
        end
        checkVal("burst.pulses",  pulses,  QEN ? 4 : 1);
        checkVal("burst.drops",   drops,   QEN ? 2 : 5);
        checkVal("burst.maxPend", maxPend, QEN ? 3 : 0);
        drain("burst");

        // Trigger on the final GAP cycle with an empty queue.
        startScenario();
        for (int i = 0; i < 110; i++) applyStimulus((i == 0) || (i == 50), "gapEnd");
        checkVal("gapEnd.pin@50",  int'(pinLog[50]),  0);
        checkVal("gapEnd.pin@51",  int'(pinLog[51]),  QEN ? 1 : 0);
        checkVal("gapEnd.busy@51", int'(busyLog[51]), QEN ? 1 : 0);
        checkVal("gapEnd.drop@51", int'(dropLog[51]), QEN ? 0 : 1);
        drain("gapEnd");

        // Reset in the middle of HIGH with two requests queued.
        startScenario();
        for (int i = 0; i < 10; i++) applyStimulus((i == 0) || (i == 3) || (i == 4), "midReset");
        checkVal("midReset.pendBefore", int'(Pend_Cnt), QEN ? 2 : 0);
        checkVal("midReset.pinBefore",  int'(Pin_Out),  1);
        RSTn = 1'b0;
        #1;
        checkAllZero("midReset.asserted");
        modelReset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        startScenario();
        for (int i = 0; i < 60; i++) applyStimulus(i == 0, "afterReset");
        highCycles = 0;
        for (int i = 0; i <= 60; i++) if (pinLog[i]) highCycles++;
        checkVal("afterReset.highCycles", highCycles, 20);
        checkVal("afterReset.pin@1", int'(pinLog[1]), 1);
        drain("afterReset");

        // Random triggers against the model.
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 29) == 0, "random");
        drain("random");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
